// File: rtl/wb_spram_arbiter_pkg.sv
// ============================================================================
// Module   : wb_spram_arbiter_pkg
// Purpose  : Shared types and constants for the two-port Wishbone SPRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_spram_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int   NPORTS     = 2;
  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_spram_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way round-robin; on a tie the port that did not
//            win last time is chosen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;
  assign grant = (&req) ? ~last_grant : req[1];

endmodule

`default_nettype wire

// File: rtl/wb_spram_arbiter.sv
// ============================================================================
// Module   : wb_spram_arbiter
// Purpose  : Shares one 1-cycle-latency single-port RAM between an instruction
//            (port 0) and a data (port 1) Wishbone classic slave port.
// Options  : WB_SPRAM_ARBITER_ERR_EN - out-of-range addresses return err and
//            leave the RAM untouched (default: addresses wrap, err tied low).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_spram_arbiter
  import wb_spram_arbiter_pkg::*;
#(
  parameter int unsigned SIZE       = 'h10000,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE) - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            s_cyc,
  input  logic [NPORTS-1:0]            s_stb,
  input  logic [NPORTS-1:0]            s_we,
  input  logic [NPORTS-1:0][3:0]       s_sel,
  input  logic [NPORTS-1:0][31:0]      s_adr,
  input  logic [NPORTS-1:0][31:0]      s_dat_i,
  output logic [NPORTS-1:0][31:0]      s_dat_o,
  output logic [NPORTS-1:0]            s_ack,
  output logic [NPORTS-1:0]            s_err,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic                         ram_ce,
  output logic [3:0]                   ram_we,
  output logic [31:0]                  ram_d,
  input  logic [31:0]                  ram_q
);

  localparam int BYTE_AW = $clog2(SIZE);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;
  logic [1:0]  w_req;
  logic        w_grant;
  logic        w_valid;
  logic        w_addr_err;
  logic        unused_adr;

  assign w_req      = s_cyc & s_stb;
  assign unused_adr = ^s_adr;

  rr_arbiter2 u_rr (
    .req        (w_req),
    .last_grant (last_grant_q),
    .grant      (w_grant),
    .valid      (w_valid)
  );

`ifdef WB_SPRAM_ARBITER_ERR_EN
  assign w_addr_err = |(s_adr[w_grant] >> BYTE_AW);
`else
  assign w_addr_err = 1'b0;
`endif

  // Read data is broadcast; only the matching ack qualifies it.
  assign s_dat_o = {ram_q, ram_q};

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    ram_ce       = 1'b0;
    ram_addr     = '0;
    ram_we       = 4'b0;
    ram_d        = '0;
    s_ack        = '0;
    s_err        = '0;

    case (state_q)
      IDLE: begin
        if (w_valid) begin
          ram_ce       = ~w_addr_err;
          ram_addr     = s_adr[w_grant][ADDR_WIDTH+1:2];
          ram_we       = (s_we[w_grant] && !w_addr_err) ? s_sel[w_grant] : 4'b0;
          ram_d        = s_dat_i[w_grant];
          gnt_d        = w_grant;
          last_grant_d = w_grant;
          err_d        = w_addr_err;
          state_d      = ACK;
        end
      end
      ACK: begin
        // The master's stb is still high here, so requests are not sampled.
        if (err_q) s_err[gnt_q] = s_cyc[gnt_q];
        else       s_ack[gnt_q] = s_cyc[gnt_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ram_ce = 1'b0;
      ram_we = 4'b0;
      s_ack  = '0;
      s_err  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= PORT_INSTR;
      last_grant_q <= PORT_DATA;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

`default_nettype wire
